// File: rtl/axil_uart_regs_if.sv
// AXI4-Lite slave bus bundle for axil_uart_regs; the slave modport is used by the register block.
interface axil_uart_regs_if #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
);
    logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                      S_AXI_AWVALID;
    logic                      S_AXI_AWREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                      S_AXI_WVALID;
    logic                      S_AXI_WREADY;
    logic [1:0]                S_AXI_BRESP;
    logic                      S_AXI_BVALID;
    logic                      S_AXI_BREADY;
    logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                      S_AXI_ARVALID;
    logic                      S_AXI_ARREADY;
    logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                S_AXI_RRESP;
    logic                      S_AXI_RVALID;
    logic                      S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axil_uart_regs.sv
// AXI4-Lite register front end for a UART with TX/RX FIFOs; independent write and read FSMs.
// Define AXIL_UART_IRQ_EN to enable the level interrupt and the CTRL.irq_en bit.
module axil_uart_regs #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic       Clk,
    input  logic       Resetn,
    axil_uart_regs_if.slave s_axi,
    output logic [7:0] TX_data,
    output logic       wr_uart_en,
    input  logic       Full,
    input  logic [7:0] RX_data,
    output logic       rd_uart_en,
    input  logic       Empty,
    output logic       Enable_rx,
    output logic       Enable_tx,
    output logic       irq,
    output logic       dbg_w_state_o,
    output logic       dbg_r_state_o
);
    // Handshakes: a channel transfers on the cycle its VALID and READY are both 1 at posedge Clk.
    // AWREADY/WREADY and ARREADY are combinational and only rise in IDLE while the request is valid.
    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_UART_IRQ_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
`endif

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic [1:0]              bresp_q, bresp_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [7:0]              tx_data_q, tx_data_d;
    logic                    wr_en_q, wr_en_d;
    logic [2:0]              ctrl_q, ctrl_d;
    logic                    tx_ovf_q, tx_ovf_d;
    logic                    rx_udf_q, rx_udf_d;
    logic                    aw_hs, ar_hs;
    logic                    tx_ovf_set, tx_ovf_clr, rx_udf_set, rx_udf_clr;
    logic                    rd_en;
    logic [1:0]              waddr, raddr;

    assign waddr = s_axi.S_AXI_AWADDR[3:2];
    assign raddr = s_axi.S_AXI_ARADDR[3:2];

    always_comb begin
        w_state_d  = w_state_q;
        bresp_d    = bresp_q;
        tx_data_d  = tx_data_q;
        wr_en_d    = 1'b0;
        ctrl_d     = ctrl_q;
        aw_hs      = 1'b0;
        tx_ovf_set = 1'b0;
        tx_ovf_clr = 1'b0;
        rx_udf_clr = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (Resetn && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID) begin
                    aw_hs     = 1'b1;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    case (waddr)
                        2'd0: begin
                            if (Full) begin
                                tx_ovf_set = 1'b1;
                                bresp_d    = RESP_SLVERR;
                            end else if (s_axi.S_AXI_WSTRB[0]) begin
                                wr_en_d   = 1'b1;
                                tx_data_d = s_axi.S_AXI_WDATA[7:0];
                            end
                        end
                        2'd2: begin
                            tx_ovf_clr = s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[2];
                            rx_udf_clr = s_axi.S_AXI_WSTRB[0] & s_axi.S_AXI_WDATA[3];
                        end
                        2'd3: begin
                            if (s_axi.S_AXI_WSTRB[0]) ctrl_d = s_axi.S_AXI_WDATA[2:0] & CTRL_MASK;
                        end
                        default: ;
                    endcase
                end
            end
            W_RESP: begin
                if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d  = r_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        ar_hs      = 1'b0;
        rd_en      = 1'b0;
        rx_udf_set = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (Resetn && s_axi.S_AXI_ARVALID) begin
                    ar_hs     = 1'b1;
                    r_state_d = R_DATA;
                    rresp_d   = RESP_OKAY;
                    rdata_d   = '0;
                    case (raddr)
                        2'd1: begin
                            if (Empty) begin
                                rresp_d    = RESP_SLVERR;
                                rx_udf_set = 1'b1;
                            end else begin
                                rd_en        = 1'b1;
                                rdata_d[7:0] = RX_data;
                            end
                        end
                        2'd2:    rdata_d[3:0] = {rx_udf_q, tx_ovf_q, Full, Empty};
                        2'd3:    rdata_d[2:0] = ctrl_q;
                        default: ;
                    endcase
                end
            end
            R_DATA: begin
                if (s_axi.S_AXI_RREADY) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Sticky flags: a new event in the same cycle as its W1C keeps the flag set.
    assign tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~tx_ovf_clr);
    assign rx_udf_d = rx_udf_set | (rx_udf_q & ~rx_udf_clr);

    always_ff @(posedge Clk) begin
        if (!Resetn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            tx_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            ctrl_q    <= 3'b000;
            tx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            tx_data_q <= tx_data_d;
            wr_en_q   <= wr_en_d;
            ctrl_q    <= ctrl_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_udf_q  <= rx_udf_d;
        end
    end

`ifdef AXIL_UART_IRQ_EN
    logic irq_q;
    always_ff @(posedge Clk) begin
        if (!Resetn) irq_q <= 1'b0;
        else         irq_q <= ctrl_q[2] & (~Empty | tx_ovf_q | rx_udf_q);
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign s_axi.S_AXI_AWREADY = aw_hs;
    assign s_axi.S_AXI_WREADY  = aw_hs;
    assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = ar_hs;
    assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;

    assign TX_data       = tx_data_q;
    assign wr_uart_en    = wr_en_q;
    assign rd_uart_en    = rd_en;
    assign Enable_rx     = ctrl_q[0];
    assign Enable_tx     = ctrl_q[1];
    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;
endmodule
